// File: rtl/pwm_param_ctrl.sv
// Duty/frequency setpoints -> PWM period/high-time via one shared 32-bit restoring divider.
// 66 cycles LATCH->WAIT, commit on next pwm_period_end; no backpressure, presses always accepted.
module pwm_param_ctrl #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned DUTY_MAX  = 99,
  parameter int unsigned DUTY_STEP = 2,
  parameter int unsigned FREQ_MAX  = 200,
  parameter int unsigned FREQ_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        press_duty,
  input  logic        press_freq,
  input  logic        pwm_period_end,
  output logic [7:0]  duty,
  output logic [8:0]  frequency,
  output logic [23:0] period,
  output logic [23:0] htime,
  output logic        load,
  output logic        busy
);

  localparam logic [7:0]  DUTY_MAX_W  = 8'(DUTY_MAX);
  localparam logic [7:0]  DUTY_STEP_W = 8'(DUTY_STEP);
  localparam logic [8:0]  FREQ_MAX_W  = 9'(FREQ_MAX);
  localparam logic [8:0]  FREQ_STEP_W = 9'(FREQ_STEP);
  localparam logic [31:0] CLK_HZ_W    = 32'(CLK_HZ);
  localparam logic [31:0] P_RST       = 32'(CLK_HZ / FREQ_MAX);
  localparam logic [31:0] H_RST       = 32'((CLK_HZ / FREQ_MAX) * DUTY_MAX / 100);

  typedef enum logic [2:0] {IDLE, LATCH, DIV_P, MUL, DIV_H, WAIT} state_t;

  state_t      state, state_nxt;
  logic        pending;
  logic [7:0]  duty_snap;
  logic [31:0] rem, quo, dvsr;
  logic [4:0]  cnt;
  logic [23:0] p_stage, h_stage;

  logic        press_any;
  logic        commit;
  logic [32:0] trial, diff;
  logic        take;
  logic [31:0] rem_step, quo_step, product;

  assign press_any = press_duty | press_freq;
  assign busy      = (state != IDLE);
  assign commit    = (state == WAIT) && pwm_period_end && !press_any && !pending;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign trial    = {rem, quo[31]};
  assign diff     = trial - {1'b0, dvsr};
  assign take     = ~diff[32];
  assign rem_step = take ? diff[31:0] : trial[31:0];
  assign quo_step = {quo[30:0], take};
  assign product  = quo * {24'd0, duty_snap};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty      <= DUTY_MAX_W;
      frequency <= FREQ_MAX_W;
      pending   <= 1'b0;
    end else begin
      if (press_duty)
        duty <= (duty <= DUTY_STEP_W) ? DUTY_MAX_W : duty - DUTY_STEP_W;
      if (press_freq)
        frequency <= (frequency <= FREQ_STEP_W) ? FREQ_MAX_W : frequency - FREQ_STEP_W;
      // A press landing in LATCH outranks the clear, so that press still gets computed.
      pending <= press_any | (pending & (state != LATCH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending) state_nxt = LATCH;
      LATCH:   state_nxt = DIV_P;
      DIV_P:   if (cnt == 5'd31) state_nxt = MUL;
      MUL:     state_nxt = DIV_H;
      DIV_H:   if (cnt == 5'd31) state_nxt = (pending || press_any) ? LATCH : WAIT;
      WAIT: begin
        if (pending || press_any) state_nxt = LATCH;
        else if (pwm_period_end)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_snap <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      p_stage   <= '0;
      h_stage   <= '0;
    end else begin
      case (state)
        LATCH: begin
          duty_snap <= duty;
          rem       <= '0;
          quo       <= CLK_HZ_W;
          dvsr      <= {23'd0, frequency};
          cnt       <= '0;
        end
        DIV_P: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 5'd1;
        end
        MUL: begin
          p_stage <= quo[23:0];
          rem     <= '0;
          quo     <= product;
          dvsr    <= 32'd100;
          cnt     <= '0;
        end
        DIV_H: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) h_stage <= quo_step[23:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= P_RST[23:0];
      htime  <= H_RST[23:0];
      load   <= 1'b0;
    end else begin
      load <= commit;
      if (commit) begin
        period <= p_stage;
        htime  <= h_stage;
      end
    end
  end

endmodule
